// File: rtl/score_tally_if.sv
// score_tally_if: links the score-keeper to score_tally.
// The score-keeper drives the add1/add2/sub2 levels. The tally drives the
// BCD score, the win and clamp flags and the seven-segment patterns.
interface score_tally_if;
  logic       add1;
  logic       add2;
  logic       sub2;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       win;
  logic       clamped;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  modport master (
    output add1, add2, sub2,
    input  ones, tens, win, clamped, HEX0, HEX1
  );

  modport slave (
    input  add1, add2, sub2,
    output ones, tens, win, clamped, HEX0, HEX1
  );
endinterface

// File: rtl/score_tally.sv
// score_tally: a two-digit BCD running score fed by +1/+2/-2 level requests.
// A request counts once, on its rising edge. The score saturates at 99 and
// floors at 00. Once the score reaches WIN_SCORE it freezes and win latches.
// Optional feature macro: SCORE_TALLY_SEG_EN. It enables the seven-segment
// decoder and blinks the display after a win. Without it, HEX0 and HEX1
// stay blank (7'h7F).
//
// state | meaning
// PLAY  | events update the score
// WON   | win asserted, score frozen until Reset
module score_tally #(
  parameter int WIN_SCORE = 21
) (
  input logic          Clock,
  input logic          Reset,
  score_tally_if.slave st
);

  typedef enum logic {PLAY, WON} state_t;

  localparam logic [7:0] WIN_BIN = 8'(WIN_SCORE);

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       clamped_q, clamped_d;
  logic [2:0] hist_q, hist_d;
  logic [2:0] evt;
  logic [7:0] score_d;

  // Edge detection, BCD update with priority sub2 > add2 > add1, and the win FSM.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    clamped_d = 1'b0;
    hist_d    = {st.sub2, st.add2, st.add1};
    evt       = {st.sub2, st.add2, st.add1} & ~hist_q;
    score_d   = 8'd0;

    if (state_q == PLAY) begin
      if (evt[2]) begin
        if (tens_q == 4'd0 && ones_q < 4'd2) begin
          ones_d    = 4'd0;
          clamped_d = 1'b1;
        end else if (ones_q >= 4'd2) begin
          ones_d = ones_q - 4'd2;
        end else begin
          ones_d = ones_q + 4'd8;
          tens_d = tens_q - 4'd1;
        end
      end else if (evt[1]) begin
        if (tens_q == 4'd9 && ones_q >= 4'd8) begin
          ones_d = 4'd9;
        end else if (ones_q >= 4'd8) begin
          ones_d = ones_q - 4'd8;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd2;
        end
      end else if (evt[0]) begin
        if (tens_q == 4'd9 && ones_q == 4'd9) begin
          ones_d = 4'd9;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      score_d = ({4'd0, tens_d} * 8'd10) + {4'd0, ones_d};
      if (score_d >= WIN_BIN) state_d = WON;
    end
  end

  // Score, history and FSM registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= PLAY;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      clamped_q <= 1'b0;
      hist_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      clamped_q <= clamped_d;
      hist_q    <= hist_d;
    end
  end

  assign st.ones    = ones_q;
  assign st.tens    = tens_q;
  assign st.win     = (state_q == WON);
  assign st.clamped = clamped_q;

`ifdef SCORE_TALLY_SEG_EN
  logic [23:0] blink_q, blink_d;
  logic        blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Free-running counter; its top bit selects the blanked half of the blink.
  always_comb begin
    blink_d = blink_q + 24'd1;
  end

  // Blink counter register.
  always_ff @(posedge Clock) begin
    if (!Reset) blink_q <= 24'd0;
    else        blink_q <= blink_d;
  end

  assign blank   = (state_q == WON) && blink_q[23];
  assign st.HEX0 = blank ? 7'h7F : seg7(ones_q);
  assign st.HEX1 = blank ? 7'h7F : seg7(tens_q);
`else
  assign st.HEX0 = 7'h7F;
  assign st.HEX1 = 7'h7F;
`endif

endmodule

// File: doc/score_tally.md
# score_tally

Consumer end of the score-event interface. Takes the `add1`, `add2` and `sub2` level outputs of the per-player score-keeper FSM and keeps a two-digit BCD running score. It detects the win condition and drives two seven-segment displays. One instance sits per player between the score-keeper and the HEX pins.

## Interface
Parameters:
- `WIN_SCORE`, default 21: score at or above which `win` latches. Legal range 1..99.

Ports:
- `Clock`, input, 1: sole clock; all state updates on its rising edge.
- `Reset`, input, 1: synchronous, active-low reset. Sampled on `Clock` rising edge.
- `add1`, input, 1: +1 request level from the score-keeper.
- `add2`, input, 1: +2 request level from the score-keeper.
- `sub2`, input, 1: −2 request level from the score-keeper.
- `ones`, output, 4: BCD ones digit of the score, 0..9.
- `tens`, output, 4: BCD tens digit of the score, 0..9.
- `win`, output, 1: sticky flag; score reached `WIN_SCORE`.
- `clamped`, output, 1: one-cycle pulse; a −2 was floored at 0.
- `HEX0`, output, 7: active-low segments {g..a} for the ones digit.
- `HEX1`, output, 7: active-low segments {g..a} for the tens digit.

## Operation
- Inputs are levels and may stay high for many cycles. Each input has a 1-cycle history register.
- Event on input X in a cycle = X sampled 1 and history(X) = 0. Exactly one score update per rising edge of X.
- A direct level change, such as add1 → add2 with no idle cycle, counts as a new add2 event.
- Priority when more than one event qualifies in the same cycle: `sub2` > `add2` > `add1`. Lower-priority events in that cycle are discarded.
- History registers update every cycle for all three inputs, whether or not an event is taken.
- Score is held directly as BCD. There is no binary-to-BCD converter.
  - +1: ones = 9 → ones = 0 and tens+1; otherwise ones+1.
  - +2: ones ≥ 8 → ones−8 and tens+1; otherwise ones+2.
  - −2: ones ≥ 2 → ones−2; otherwise ones+8 and tens−1.
- Upper saturation at 99. A +1/+2 from 98 or 99 yields 99. The tens digit never exceeds 9.
- Floor at 0.
  - −2 from 0 or 1 yields 00.
  - `clamped` pulses in the same update cycle when the clamp reduced the magnitude of the change.
  - −2 from exactly 2 is not a clamp.
- Win FSM states:
  - PLAY: events update the score.
  - WON: entered on the edge where the updated score ≥ `WIN_SCORE`. `win` = 1, score frozen, all further events ignored.
  - Exit from WON only through `Reset`.
- Crossing past `WIN_SCORE` in a single +2 step is kept as-is. For example, 20 + 2 gives 22 when `WIN_SCORE` = 21; the score is not trimmed to 21.
- Reset (`Reset` = 0 at an edge), every output at the next edge:
  - ones = 0, tens = 0, win = 0, clamped = 0.
  - History registers = 0.
  - State = PLAY.
- Reset overrides any simultaneous event.
- An input already held high when reset releases counts as a new event on the first non-reset cycle, because its history was cleared.

## Timing
- Latency: input sampled 1 at edge N, with history 0, gives the updated `ones`/`tens` visible after edge N.
- `win` rises at the same edge as the score update that triggers it.
- `clamped` is high for exactly one cycle, after the update edge.
- `HEX0`/`HEX1` are combinational from `ones`/`tens` and follow them within the same cycle.
- No back-pressure and no handshake. The score-keeper's 1-cycle state-register delay is absorbed by edge detection.
- Sustained throughput: one event per two cycles per input. Alternating inputs give one event per cycle.

## Configuration
- `SCORE_TALLY_SEG_EN` defined:
  - `HEX0`/`HEX1` decode digits 0..9 to standard active-low patterns (0 → 7'b1000000, 1 → 7'b1111001, …).
  - While `win` = 1, `HEX1` and `HEX0` blink: the pattern is forced to 7'h7F on alternate 2^23-cycle halves of an internal free-running counter, which resets to 0.
- `SCORE_TALLY_SEG_EN` not defined:
  - No decoder and no blink counter.
  - `HEX0` = `HEX1` = 7'h7F (all segments off).
  - The remaining behaviour is identical.

## Test plan
- Reset held 3 cycles with `add2` = 1, then released → ones = 0, tens = 0, win = 0 during reset; the first released edge gives score 02.
- `add1` held high for 10 cycles → score 01 only, not 10. Drop, then reassert → 02.
- Score 09, `add1` edge → tens = 1, ones = 0. Score 18, `add2` edge → 20.
- Score 01, `sub2` edge → 00 with `clamped` = 1 for one cycle. Score 02, `sub2` → 00 with `clamped` = 0. Score 10, `sub2` → 08.
- `WIN_SCORE` = 21, score 20, `add2` edge → score 22, win = 1. Further `add1`/`add2`/`sub2` edges leave score at 22. `Reset` low returns score 00 and win = 0.
- `add1`, `add2` and `sub2` rise in the same cycle at score 05 → 03 (`sub2` wins). With `SCORE_TALLY_SEG_EN` defined, `HEX0` = 7'b0110000 and `HEX1` = 7'b1000000.
